// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the unified-memory access sequencer.
// Covers the FSM states, the address-select codes, the requester IDs and the arbitration modes.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    ACK,
    ERR
  } state_t;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_PC  = 2'b00;
  localparam sel_t SEL_R6  = 2'b01;
  localparam sel_t SEL_ALU = 2'b10;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } req_id_t;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  // Request attributes captured at grant time.
  typedef struct packed {
    req_id_t who;
    logic    we;
    logic    word;
    logic    src;
  } xfer_t;

  // Registered controller outputs, kept together as one register.
  typedef struct packed {
    logic if_ack;
    logic if_err;
    logic d_ack;
    logic d_err;
    logic mem_rd;
    logic mem_wr;
    logic ctrl;
    logic ir_wr;
    logic mdr_l;
    logic mdr_h;
    sel_t addr_sel;
    logic busy;
  } outs_t;

  function automatic sel_t sel_for(xfer_t x);
    if (x.who == FETCH) return SEL_PC;
    return x.src ? SEL_ALU : SEL_R6;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester handshake and memory-control bundle between the requesters and mem_access_ctrl.
// The master side is the requester/datapath, and the slave side is the controller.
interface mem_access_ctrl_if
  import mem_ctrl_pkg::*;
  ;
  logic if_req;
  logic if_addr0;
  logic if_ack;
  logic if_err;
  logic d_req;
  logic d_we;
  logic d_word;
  logic d_src;
  logic d_addr0;
  logic d_ack;
  logic d_err;
  logic mem_rd;
  logic mem_wr;
  logic ctrl;
  logic ir_wr;
  logic mdr_l;
  logic mdr_h;
  sel_t addr_sel;
  logic busy;

  modport master (
    output if_req, if_addr0, d_req, d_we, d_word, d_src, d_addr0,
    input  if_ack, if_err, d_ack, d_err,
    input  mem_rd, mem_wr, ctrl, ir_wr, mdr_l, mdr_h, addr_sel, busy
  );

  modport slave (
    input  if_req, if_addr0, d_req, d_we, d_word, d_src, d_addr0,
    output if_ack, if_err, d_ack, d_err,
    output mem_rd, mem_wr, ctrl, ir_wr, mdr_l, mdr_h, addr_sel, busy
  );

endinterface

// File: rtl/mem_access_ctrl_arb.sv
// Two-way arbiter between instruction fetch and load/store.
// It uses fixed data-first priority or round-robin, and last_grant is owned here.
module mem_arb2
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE = PRIO_FIXED
) (
  input  logic clock,
  input  logic reset,
  input  logic req_fetch,
  input  logic req_data,
  input  logic grant_en,
  output logic grant_fetch,
  output logic grant_data
);

  req_id_t last_grant;

  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (grant_en) begin
      if (req_fetch && req_data) begin
        if (PRIORITY_MODE == PRIO_RR && last_grant == DATA)
          grant_fetch = 1'b1;
        else
          grant_data = 1'b1;
      end else begin
        grant_fetch = req_fetch;
        grant_data  = req_data;
      end
    end
  end

  // Error grants count too, so a misaligned requester still yields its turn.
  always_ff @(posedge clock) begin
    if (reset)
      last_grant <= FETCH;
    else if (grant_fetch)
      last_grant <= FETCH;
    else if (grant_data)
      last_grant <= DATA;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences fetch and load/store accesses to the unified memory: arbitration, wait states,
// strobe generation and misalignment rejection, with one-cycle acks and registered outputs.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES   = 1,
  parameter int unsigned PRIORITY_MODE = PRIO_FIXED
) (
  input logic              clock,
  input logic              reset,
  mem_access_ctrl_if.slave bus
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t     state, state_nxt;
  xfer_t      xfer, xfer_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  outs_t      o, o_nxt;
  logic       grant_fetch, grant_data;
  logic       misalign;

  mem_arb2 #(
    .PRIORITY_MODE(PRIORITY_MODE)
  ) u_arb (
    .clock      (clock),
    .reset      (reset),
    .req_fetch  (bus.if_req),
    .req_data   (bus.d_req),
    .grant_en   (state == IDLE),
    .grant_fetch(grant_fetch),
    .grant_data (grant_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      xfer  <= '0;
      wcnt  <= '0;
      o     <= '0;
    end else begin
      state <= state_nxt;
      xfer  <= xfer_nxt;
      wcnt  <= wcnt_nxt;
      o     <= o_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    xfer_nxt  = xfer;
    wcnt_nxt  = wcnt;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_fetch) begin
          xfer_nxt = '{who: FETCH, we: 1'b0, word: 1'b1, src: 1'b0};
          misalign = bus.if_addr0;
        end else if (grant_data) begin
          xfer_nxt = '{who: DATA, we: bus.d_we, word: bus.d_word, src: bus.d_src};
          misalign = bus.d_word & bus.d_addr0;
        end
        if (grant_fetch || grant_data) begin
          wcnt_nxt = WAIT_LOAD;
          if (misalign)
            state_nxt = ERR;
          else if (WAIT_CYCLES == 0)
            state_nxt = STROBE;
          else
            state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (wcnt == 4'd0)
          state_nxt = STROBE;
        else
          wcnt_nxt = wcnt - 4'd1;
      end
      STROBE:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode the next state so they land in the register alongside it.
  always_comb begin
    o_nxt      = '0;
    o_nxt.busy = (state_nxt != IDLE);
    case (state_nxt)
      SETUP: o_nxt.addr_sel = sel_for(xfer_nxt);
      STROBE: begin
        o_nxt.addr_sel = sel_for(xfer_nxt);
        if (xfer_nxt.who == FETCH) begin
          o_nxt.mem_rd = 1'b1;
          o_nxt.ir_wr  = 1'b1;
        end else if (xfer_nxt.we) begin
          o_nxt.mem_wr = 1'b1;
          o_nxt.ctrl   = xfer_nxt.word;
        end else begin
          o_nxt.mem_rd = 1'b1;
          o_nxt.mdr_l  = 1'b1;
          o_nxt.mdr_h  = xfer_nxt.word;
        end
      end
      ACK: begin
        o_nxt.addr_sel = sel_for(xfer_nxt);
        if (xfer_nxt.who == FETCH)
          o_nxt.if_ack = 1'b1;
        else
          o_nxt.d_ack = 1'b1;
      end
      ERR: begin
        if (xfer_nxt.who == FETCH) begin
          o_nxt.if_ack = 1'b1;
          o_nxt.if_err = 1'b1;
        end else begin
          o_nxt.d_ack = 1'b1;
          o_nxt.d_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.if_ack   = o.if_ack;
  assign bus.if_err   = o.if_err;
  assign bus.d_ack    = o.d_ack;
  assign bus.d_err    = o.d_err;
  assign bus.mem_rd   = o.mem_rd;
  assign bus.mem_wr   = o.mem_wr;
  assign bus.ctrl     = o.ctrl;
  assign bus.ir_wr    = o.ir_wr;
  assign bus.mdr_l    = o.mdr_l;
  assign bus.mdr_h    = o.mdr_h;
  assign bus.addr_sel = o.addr_sel;
  assign bus.busy     = o.busy;

endmodule
